// File: rtl/pwm_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_driver_pkg
// Description : Shared defaults and helper functions for the servo PWM driver.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_driver_pkg;

  localparam int DEF_CLK_DIV      = 1000;
  localparam int DEF_PERIOD_TICKS = 2000;
  localparam int DEF_MIN_WIDTH    = 50;
  localparam int DEF_MAX_WIDTH    = 250;
  localparam int DEF_DATA_W       = 13;

  // Bits needed to hold 0..n-1; never below one bit so n=1 still yields a port.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Saturate a command into [mn, mx]; operands are zero-extended, so the
  // comparison is exact unsigned at the caller's full data width.
  function automatic logic [31:0] clamp_width(input logic [31:0] d,
                                              input logic [31:0] mn,
                                              input logic [31:0] mx);
    if (d < mn) begin
      return mn;
    end else if (d > mx) begin
      return mx;
    end else begin
      return d;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : pwm_tick_gen
// Description : Prescaler; emits a one-cycle tick on the last count of each
//               CLK_DIV window and flags the first count of the window.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_tick_gen
  import pwm_driver_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o,
  output logic pre_zero_o
);

  localparam int               PRE_W    = cnt_width(CLK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

  logic [PRE_W-1:0] pre_cnt_q;
  logic [PRE_W-1:0] pre_cnt_d;

  // Wrap at CLK_DIV-1; with CLK_DIV=1 the counter sits at zero and ticks every cycle.
  always_comb begin
    pre_cnt_d = (pre_cnt_q == PRE_LAST) ? '0 : pre_cnt_q + PRE_W'(1);
  end

  // Prescaler state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

  assign tick_o     = (pre_cnt_q == PRE_LAST);
  assign pre_zero_o = (pre_cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/pwm_driver.sv
`default_nettype none
// ============================================================================
// Module      : pwm_driver
// Description : Servo-style PWM generator. Latches a clamped width command at
//               each period start and drives a registered active-high pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_driver
  import pwm_driver_pkg::*;
#(
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int PERIOD_TICKS = DEF_PERIOD_TICKS,
  parameter int MIN_WIDTH    = DEF_MIN_WIDTH,
  parameter int MAX_WIDTH    = DEF_MAX_WIDTH,
  parameter int DATA_W       = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] data,
  output logic              o_signal
);

  // Width is always < PERIOD_TICKS, so the period counter width also holds it.
  localparam int               PER_W    = cnt_width(PERIOD_TICKS);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_TICKS - 1);

  // Reject parameter sets that would allow a stuck-high output or bad clamp.
  if (MIN_WIDTH > MAX_WIDTH) begin : g_chk_min_max
    $fatal(1, "pwm_driver: MIN_WIDTH must not exceed MAX_WIDTH");
  end
  if (MAX_WIDTH >= PERIOD_TICKS) begin : g_chk_max_period
    $fatal(1, "pwm_driver: MAX_WIDTH must be below PERIOD_TICKS");
  end
  if (CLK_DIV < 1) begin : g_chk_div
    $fatal(1, "pwm_driver: CLK_DIV must be at least 1");
  end
  if (DATA_W < 1 || DATA_W > 32) begin : g_chk_data_w
    $fatal(1, "pwm_driver: DATA_W must be within 1..32");
  end

  logic             tick;
  logic             pre_zero;
  logic [PER_W-1:0] per_cnt_q;
  logic [PER_W-1:0] per_cnt_d;
  logic [PER_W-1:0] duty_q;
  logic [PER_W-1:0] duty_d;
  logic [PER_W-1:0] duty_eff;
  logic             period_start;
  logic             signal_q;
  logic             signal_d;

  pwm_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .tick_o     (tick),
    .pre_zero_o (pre_zero)
  );

  // Period bookkeeping, width capture at period start and pulse compare.
  always_comb begin
    period_start = pre_zero && (per_cnt_q == '0);
    // Clamp result is <= MAX_WIDTH < PERIOD_TICKS, so the truncation is lossless.
    duty_eff     = period_start
                 ? PER_W'(clamp_width(32'(data), 32'(MIN_WIDTH), 32'(MAX_WIDTH)))
                 : duty_q;
    duty_d       = duty_eff;
    per_cnt_d    = per_cnt_q;
    if (tick) begin
      per_cnt_d = (per_cnt_q == PER_LAST) ? '0 : per_cnt_q + PER_W'(1);
    end
    signal_d     = (per_cnt_q < duty_eff);
  end

  // State and output registers; reset forces the pin low immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      per_cnt_q <= '0;
      duty_q    <= '0;
      signal_q  <= 1'b0;
    end else begin
      per_cnt_q <= per_cnt_d;
      duty_q    <= duty_d;
      signal_q  <= signal_d;
    end
  end

  assign o_signal = signal_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_driver
// Description : Self-checking bench for pwm_driver (CLK_DIV=2, 300 ticks).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_driver;

  localparam int CLK_DIV  = 2;
  localparam int PERIOD   = 300;
  localparam int MINW     = 50;
  localparam int MAXW     = 250;
  localparam int DW       = 13;
  localparam int PCYC     = PERIOD * CLK_DIV;
  localparam int GUARD    = 2000;

  logic          clk  = 1'b0;
  logic          rst  = 1'b0;
  logic [DW-1:0] data = '0;
  logic          o_signal;

  int n_checks = 0;
  int n_fail   = 0;

  pwm_driver #(
    .CLK_DIV      (CLK_DIV),
    .PERIOD_TICKS (PERIOD),
    .MIN_WIDTH    (MINW),
    .MAX_WIDTH    (MAXW),
    .DATA_W       (DW)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .data     (data),
    .o_signal (o_signal)
  );

  always #5 clk = ~clk;

  function automatic int clamp_m(input int d);
    if (d < MINW) return MINW;
    if (d > MAXW) return MAXW;
    return d;
  endfunction

  // Reference: cycle index within the period and the width latched at cycle 0.
  int   t_m = 0;
  int   w_m = 0;
  logic exp_o = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t_m   <= 0;
      exp_o <= 1'b0;
    end else begin
      w_m   <= (t_m == 0) ? clamp_m(int'(data)) : w_m;
      exp_o <= (t_m < ((t_m == 0) ? clamp_m(int'(data)) : w_m) * CLK_DIV);
      t_m   <= (t_m + 1) % PCYC;
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Pulse reset across one negedge; reset-state output checked while asserted.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_o_signal", int'(o_signal), 0);
    rst = 1'b0;
  endtask

  // Count consecutive negedge samples at level lvl; stops at first other sample.
  task automatic run_while(input logic lvl, output int n);
    n = 0;
    while (o_signal == lvl && n < GUARD) begin
      n++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    int data;
    int exp_hi;
    int exp_lo;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int hi, lo, hi2, first;

    vecs[0] = '{50,   100, 500};
    vecs[1] = '{250,  500, 100};
    vecs[2] = '{10,   100, 500};
    vecs[3] = '{4000, 500, 100};
    vecs[4] = '{150,  300, 300};
    vecs[5] = '{49,   100, 500};
    vecs[6] = '{251,  500, 100};
    vecs[7] = '{0,    100, 500};
    vecs[8] = '{8191, 500, 100};

    // Table: reset, first-edge rise, high and low lengths.
    for (int i = 0; i < 9; i++) begin
      data = DW'(vecs[i].data);
      do_reset();
      @(negedge clk);
      first = int'(o_signal);
      check("first_edge_rise", first, 1);
      run_while(1'b1, hi);
      run_while(1'b0, lo);
      check($sformatf("high_len d=%0d", vecs[i].data), hi, vecs[i].exp_hi);
      check($sformatf("low_len d=%0d", vecs[i].data), lo, vecs[i].exp_lo);
    end

    // Mid-period command change is deferred to the next period.
    data = DW'(50);
    do_reset();
    @(negedge clk);
    repeat (30) @(negedge clk);
    data = DW'(150);
    run_while(1'b1, hi);
    run_while(1'b0, lo);
    run_while(1'b1, hi2);
    check("change_cur_high", hi + 30, 100);
    check("change_low", lo, 500);
    check("change_next_high", hi2, 300);

    // Reset asserted during the high phase drops the pin without a clock.
    data = DW'(250);
    do_reset();
    @(negedge clk);
    repeat (40) @(negedge clk);
    check("pre_reset_high", int'(o_signal), 1);
    #2 rst = 1'b1;
    #1 check("async_reset_low", int'(o_signal), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("restart_rise", int'(o_signal), 1);
    run_while(1'b1, hi);
    check("restart_high", hi, 500);

    // Random commands checked cycle by cycle against the reference.
    data = DW'($urandom_range(0, 400));
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      check($sformatf("random_cycle %0d", c), int'(o_signal), int'(exp_o));
      if ($urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 7) == 0) data = DW'($urandom);
        else                           data = DW'($urandom_range(0, 400));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
